// File: rtl/sc_speed_level_counter.sv
// Saturating speed register updated once per prescaler tick from active-low
// accelerate/brake/clear requests, with optional coast-down when idle.
module sc_speed_level_counter #(
   parameter int DATAWIDTH = 8,
   parameter int MAXSPEED  = 200,
   parameter int ACCELSTEP = 1,
   parameter int BRAKESTEP = 2,
   parameter int PRESCALE  = 1000,
   parameter int COAST_EN  = 1
) (
   input  logic                 sc_speed_level_counter_CLOCK_50,
   input  logic                 sc_speed_level_counter_RESET_InHigh,
   input  logic                 sc_speed_level_counter_accel_InLow,
   input  logic                 sc_speed_level_counter_brake_InLow,
   input  logic                 sc_speed_level_counter_T0_InLow,
   output logic [DATAWIDTH-1:0] sc_speed_level_counter_data_OutBUS,
   output logic                 sc_speed_level_counter_max_OutHigh,
   output logic                 sc_speed_level_counter_zero_OutHigh,
   output logic                 sc_speed_level_counter_tick_OutHigh
);

   localparam int CNTW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int EXTW = DATAWIDTH + 1;

   localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(PRESCALE - 1);
   localparam logic [EXTW-1:0] MAX_EXT   = EXTW'(MAXSPEED);
   localparam logic [EXTW-1:0] ACCEL_EXT = EXTW'(ACCELSTEP);
   localparam logic [EXTW-1:0] BRAKE_EXT = EXTW'(BRAKESTEP);
   localparam logic [EXTW-1:0] ONE_EXT   = EXTW'(1);

   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [DATAWIDTH-1:0] speed_q, speed_d;
   logic                 tick_q, tick_d;

   logic                 tick_int;
   logic [EXTW-1:0]      speed_ext;
   logic [EXTW-1:0]      accel_sum;
   logic [EXTW-1:0]      next_ext;

   assign tick_int  = (cnt_q == CNT_LAST);
   assign speed_ext = {1'b0, speed_q};
   assign accel_sum = speed_ext + ACCEL_EXT;

   // Update value chosen by request priority; evaluated at full width+1 so
   // both saturation limits are exact.
   always_comb begin
      next_ext = speed_ext;
      if (!sc_speed_level_counter_brake_InLow) begin
         next_ext = (speed_ext < BRAKE_EXT) ? '0 : (speed_ext - BRAKE_EXT);
      end else if (!sc_speed_level_counter_accel_InLow) begin
         next_ext = (accel_sum > MAX_EXT) ? MAX_EXT : accel_sum;
      end else if (COAST_EN != 0) begin
         next_ext = (speed_ext < ONE_EXT) ? '0 : (speed_ext - ONE_EXT);
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      speed_d = speed_q;
      tick_d  = 1'b0;
      if (!sc_speed_level_counter_T0_InLow) begin
         cnt_d   = '0;
         speed_d = '0;
      end else if (tick_int) begin
         cnt_d   = '0;
         speed_d = next_ext[DATAWIDTH-1:0];
         tick_d  = 1'b1;
      end else begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge sc_speed_level_counter_CLOCK_50) begin
      if (sc_speed_level_counter_RESET_InHigh) begin
         cnt_q   <= '0;
         speed_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
         tick_q  <= tick_d;
      end
   end

   assign sc_speed_level_counter_data_OutBUS  = speed_q;
   assign sc_speed_level_counter_max_OutHigh  = (speed_ext == MAX_EXT);
   assign sc_speed_level_counter_zero_OutHigh = (speed_q == '0);
   assign sc_speed_level_counter_tick_OutHigh = tick_q;

endmodule

// File: tb/tb_sc_speed_level_counter.sv
// Bench for sc_speed_level_counter: cycle model plus directed tick-by-tick
// sequences with literal expected speeds.
module tb_sc_speed_level_counter;

   localparam int DW = 8;
   localparam int MS = 10;
   localparam int AS = 3;
   localparam int BS = 2;
   localparam int PS = 4;
   localparam int CE = 1;

   logic          clk;
   logic          rst;
   logic          accel_n;
   logic          brake_n;
   logic          t0_n;
   logic [DW-1:0] data;
   logic          max_o;
   logic          zero_o;
   logic          tick_o;

   int checks = 0;
   int errors = 0;

   sc_speed_level_counter #(
      .DATAWIDTH(DW), .MAXSPEED(MS), .ACCELSTEP(AS),
      .BRAKESTEP(BS), .PRESCALE(PS), .COAST_EN(CE)
   ) dut (
      .sc_speed_level_counter_CLOCK_50    (clk),
      .sc_speed_level_counter_RESET_InHigh(rst),
      .sc_speed_level_counter_accel_InLow (accel_n),
      .sc_speed_level_counter_brake_InLow (brake_n),
      .sc_speed_level_counter_T0_InLow    (t0_n),
      .sc_speed_level_counter_data_OutBUS (data),
      .sc_speed_level_counter_max_OutHigh (max_o),
      .sc_speed_level_counter_zero_OutHigh(zero_o),
      .sc_speed_level_counter_tick_OutHigh(tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: counts clocks since the last restart; every PS-th clock applies
   // the highest-priority request using plain integer min/max.
   int m_speed = 0;
   int m_since = 0;
   int m_tick  = 0;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_speed = 0; m_since = 0; m_tick = 0; m_valid = 1'b1;
      end else if (!t0_n) begin
         m_speed = 0; m_since = 0; m_tick = 0;
      end else begin
         m_since = m_since + 1;
         m_tick  = 0;
         if (m_since == PS) begin
            m_since = 0;
            m_tick  = 1;
            if (!brake_n)      m_speed = (m_speed - BS < 0) ? 0 : m_speed - BS;
            else if (!accel_n) m_speed = (m_speed + AS > MS) ? MS : m_speed + AS;
            else if (CE != 0)  m_speed = (m_speed - 1 < 0) ? 0 : m_speed - 1;
         end
      end
      #1;
      if (m_valid) begin
         chk("model_data", int'(data), m_speed);
         chk("model_max",  int'(max_o),  (m_speed == MS) ? 1 : 0);
         chk("model_zero", int'(zero_o), (m_speed == 0) ? 1 : 0);
         chk("model_tick", int'(tick_o), m_tick);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Waits for the next tick pulse (bounded) and reports clocks elapsed.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!tick_o && n < 3 * PS);
      if (!tick_o) begin
         errors++;
         checks++;
         $display("FAIL tick_timeout: no tick after %0d clocks", n);
      end
   endtask

   task automatic tick_expect(input string name, input int exp_data);
      int n;
      wait_tick(n);
      chk(name, int'(data), exp_data);
   endtask

   int n;
   int accel_seq [5] = '{3, 6, 9, 10, 10};
   int brake_seq [6] = '{8, 6, 4, 2, 0, 0};

   initial begin
      rst = 1'b1; accel_n = 1'b1; brake_n = 1'b1; t0_n = 1'b1;
      cyc(); cyc();
      chk("reset_data", int'(data), 0);
      chk("reset_zero", int'(zero_o), 1);
      chk("reset_max",  int'(max_o), 0);
      chk("reset_tick", int'(tick_o), 0);
      rst = 1'b0;

      // idle: ticks every PS clocks, coast holds at 0
      for (int i = 0; i < 3; i++) begin
         wait_tick(n);
         chk("idle_period", n, 4);
         chk("idle_data", int'(data), 0);
      end

      accel_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_tick(n);
         chk("accel_period", n, 4);
         chk("accel_data", int'(data), accel_seq[i]);
         chk("accel_max", int'(max_o), (i >= 3) ? 1 : 0);
      end

      brake_n = 1'b0;
      for (int i = 0; i < 6; i++) tick_expect("brake_data", brake_seq[i]);
      chk("brake_zero", int'(zero_o), 1);
      brake_n = 1'b1;

      for (int i = 0; i < 3; i++) tick_expect("climb_data", 3 * (i + 1));
      accel_n = 1'b1;
      tick_expect("coast_8", 8);
      tick_expect("coast_7", 7);
      cyc();
      accel_n = 1'b0;
      cyc();
      accel_n = 1'b1;
      tick_expect("coast_6_pulse_ignored", 6);

      accel_n = 1'b0;
      tick_expect("up_to_9", 9);
      accel_n = 1'b1;
      cyc(); cyc();
      t0_n = 1'b0;
      cyc();
      t0_n = 1'b1;
      chk("t0_data", int'(data), 0);
      chk("t0_tick", int'(tick_o), 0);
      chk("t0_zero", int'(zero_o), 1);
      wait_tick(n);
      chk("t0_restart_period", n, 4);
      chk("t0_after_coast", int'(data), 0);

      accel_n = 1'b0;
      tick_expect("acc_3", 3);
      tick_expect("acc_6", 6);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_data", int'(data), 0);
      chk("midrst_zero", int'(zero_o), 1);
      chk("midrst_tick", int'(tick_o), 0);
      wait_tick(n);
      chk("midrst_period", n, 4);
      chk("midrst_data3", int'(data), 3);

      // brief random idle tail to exercise the model across request toggles
      for (int i = 0; i < 40; i++) begin
         accel_n = 1'($urandom_range(0, 1));
         brake_n = 1'($urandom_range(0, 1));
         t0_n    = ($urandom_range(0, 15) != 0);
         cyc();
      end
      t0_n = 1'b1; accel_n = 1'b1; brake_n = 1'b1;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_speed_level_counter.md
SC_SPEED_LEVEL_COUNTER -- requirements
Module: sc_speed_level_counter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, meaning the width of the speed value.
REQ-002 The block SHALL have parameter MAXSPEED, default 200, meaning the saturation ceiling; it SHALL be legal only when 1 <= MAXSPEED <= 2^DATAWIDTH-1.
REQ-003 The block SHALL have parameter ACCELSTEP, default 1, meaning the increment per tick; it SHALL be legal only when 1 <= ACCELSTEP <= MAXSPEED.
REQ-004 The block SHALL have parameter BRAKESTEP, default 2, meaning the decrement per tick when braking; it SHALL be legal only when 1 <= BRAKESTEP <= MAXSPEED.
REQ-005 The block SHALL have parameter PRESCALE, default 1000, meaning the number of clocks per update tick; it SHALL be legal only when PRESCALE >= 1.
REQ-006 The block SHALL have parameter COAST_EN, default 1, meaning that the speed decays by 1 per tick when no command is active.
REQ-007 The block SHALL have port sc_speed_level_counter_CLOCK_50, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-008 The block SHALL have port sc_speed_level_counter_RESET_InHigh, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port sc_speed_level_counter_accel_InLow, input, 1 bit: accelerate request, active low.
REQ-010 The block SHALL have port sc_speed_level_counter_brake_InLow, input, 1 bit: brake request, active low.
REQ-011 The block SHALL have port sc_speed_level_counter_T0_InLow, input, 1 bit: immediate clear to zero, active low.
REQ-012 The block SHALL have port sc_speed_level_counter_data_OutBUS, output, DATAWIDTH bits: the registered current speed.
REQ-013 The block SHALL have port sc_speed_level_counter_max_OutHigh, output, 1 bit: high whenever speed == MAXSPEED.
REQ-014 The block SHALL have port sc_speed_level_counter_zero_OutHigh, output, 1 bit: high whenever speed == 0.
REQ-015 The block SHALL have port sc_speed_level_counter_tick_OutHigh, output, 1 bit: one-clock pulse, registered, marking the clock in which an update was applied.

Function
REQ-016 The block SHALL contain a prescaler that counts 0..PRESCALE-1, wraps to 0, and declares an internal tick in the cycle where the count equals PRESCALE-1; with PRESCALE=1, a tick SHALL occur every cycle.
REQ-017 On a tick edge, the speed update SHALL follow priority T0 > brake > accel > coast > hold; the new value SHALL be visible on data_OutBUS in the cycle after that edge (1-clock latency).
REQ-018 While T0_InLow=0, the block SHALL load speed 0 and prescaler 0 at every edge, regardless of tick; no tick pulse SHALL be issued in that cycle.
REQ-019 On a brake tick, the block SHALL set speed = speed - BRAKESTEP, saturating at 0; accel SHALL be ignored while brake is asserted.
REQ-020 On an accel tick, the block SHALL set speed = speed + ACCELSTEP, saturating at MAXSPEED.
REQ-021 On a coast tick (no request, COAST_EN=1), the block SHALL set speed = speed - 1, saturating at 0; with COAST_EN=0, it SHALL hold speed.
REQ-022 Arithmetic SHALL be computed at DATAWIDTH+1 bits so that saturation is exact; speed SHALL never exceed MAXSPEED or wrap below 0.
REQ-023 Requests SHALL be sampled only on the tick edge; request toggles between ticks SHALL have no effect.
REQ-024 tick_OutHigh SHALL pulse for exactly one clock after every tick edge that is not overridden by T0 or reset, including ticks in which the speed is unchanged (saturated or holding).
REQ-025 max_OutHigh and zero_OutHigh SHALL be decoded from the speed register only and SHALL never be asserted simultaneously (MAXSPEED >= 1).

Reset
REQ-026 While RESET_InHigh=1 at an edge, the block SHALL set speed=0, prescaler=0, tick=0; outputs after that edge SHALL be data=0, max=0, zero=1, tick=0.
REQ-027 Reset SHALL have priority over T0 and all requests; a reset asserted mid-count SHALL restart the prescaler, so that the first tick occurs PRESCALE clocks after release.

Verification (DATAWIDTH=8, MAXSPEED=10, ACCELSTEP=3, BRAKESTEP=2, PRESCALE=4, COAST_EN=1)
REQ-028 Reset then idle -> data=0, zero=1; tick pulses every 4 clocks; data stays 0 under coast.
REQ-029 accel held for 5 ticks -> data 3, 6, 9, 10, 10; max=1 from the 4th tick; tick still pulses on the saturated ticks.
REQ-030 From 10, assert brake and accel together for 6 ticks -> data 8, 6, 4, 2, 0, 0; zero=1 at the end.
REQ-031 From 9, release all requests -> coast gives 8, 7, 6 on successive ticks; an accel pulse asserted only between ticks -> no change.
REQ-032 From 9, pulse T0 low for 1 clock mid-prescale -> data=0 on the next cycle, no tick that cycle, next tick exactly 4 clocks after T0 is released.
REQ-033 Assert reset for 1 clock while accelerating at 6 -> data=0, zero=1, tick=0; first tick 4 clocks after release, giving data=3.
